// File: rtl/id_ex_ctrl.sv
// ID/EX control stage: decodes an ARM data-processing/memory/branch instruction,
// evaluates its condition on bypassed flags and registers the execute-stage command.
module id_ex_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic [3:0]  ex_flags,
    input  logic        ex_flags_we,
    output logic [3:0]  exe_cmd,
    output logic        carry_in,
    output logic        out_valid,
    output logic        wb_en,
    output logic        mem_read,
    output logic        mem_write,
    output logic        s_update,
    output logic        imm,
    output logic        branch,
    output logic [3:0]  rn,
    output logic [3:0]  rd,
    output logic [11:0] shift_operand,
    output logic [23:0] branch_offset,
    output logic [3:0]  status
);

    localparam int unsigned CMD_W   = 4;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned SHIFT_W = 12;
    localparam int unsigned OFF_W   = 24;

    typedef struct packed {
        logic               out_valid;
        logic               wb_en;
        logic               mem_read;
        logic               mem_write;
        logic               s_update;
        logic               imm;
        logic               branch;
        logic               carry_in;
        logic [CMD_W-1:0]   exe_cmd;
        logic [REG_W-1:0]   rn;
        logic [REG_W-1:0]   rd;
        logic [SHIFT_W-1:0] shift_operand;
        logic [OFF_W-1:0]   branch_offset;
    } idex_t;

    idex_t            idex_q, idex_d, dec_c;
    logic [3:0]       status_q, status_d;
    logic [3:0]       flags_c;
    logic             cond_pass_c;
    logic             dp_ok_c;
    logic [CMD_W-1:0] dp_cmd_c;

    logic [3:0] cond_f;
    logic [1:0] mode_f;
    logic [3:0] opcode_f;
    logic       s_f;

    assign cond_f   = instr[31:28];
    assign mode_f   = instr[27:26];
    assign opcode_f = instr[24:21];
    assign s_f      = instr[20];

    // Flags written back by EX this cycle win over the architectural register.
    assign flags_c = ex_flags_we ? ex_flags : status_q;

    always_comb begin
        cond_pass_c = 1'b0;
        case (cond_f)
            4'h0: cond_pass_c = flags_c[2];
            4'h1: cond_pass_c = ~flags_c[2];
            4'h2: cond_pass_c = flags_c[1];
            4'h3: cond_pass_c = ~flags_c[1];
            4'h4: cond_pass_c = flags_c[3];
            4'h5: cond_pass_c = ~flags_c[3];
            4'h6: cond_pass_c = flags_c[0];
            4'h7: cond_pass_c = ~flags_c[0];
            4'h8: cond_pass_c = flags_c[1] & ~flags_c[2];
            4'h9: cond_pass_c = ~flags_c[1] | flags_c[2];
            4'hA: cond_pass_c = (flags_c[3] == flags_c[0]);
            4'hB: cond_pass_c = (flags_c[3] != flags_c[0]);
            4'hC: cond_pass_c = ~flags_c[2] & (flags_c[3] == flags_c[0]);
            4'hD: cond_pass_c = flags_c[2] | (flags_c[3] != flags_c[0]);
            4'hE: cond_pass_c = 1'b1;
            default: cond_pass_c = 1'b0;
        endcase
    end

    always_comb begin
        dp_ok_c  = 1'b1;
        dp_cmd_c = 4'b0000;
        case (opcode_f)
            4'b1101: dp_cmd_c = 4'b0001;
            4'b1111: dp_cmd_c = 4'b1001;
            4'b0100: dp_cmd_c = 4'b0010;
            4'b0101: dp_cmd_c = 4'b0011;
            4'b0010: dp_cmd_c = 4'b0100;
            4'b0110: dp_cmd_c = 4'b0101;
            4'b0000: dp_cmd_c = 4'b0110;
            4'b1100: dp_cmd_c = 4'b0111;
            4'b0001: dp_cmd_c = 4'b1000;
            4'b1010: dp_cmd_c = 4'b0100;
            4'b1000: dp_cmd_c = 4'b0110;
            default: dp_ok_c  = 1'b0;
        endcase
    end

    // Decode into a full payload; anything not issued stays an all-zero bubble.
    always_comb begin
        dec_c = '0;
        if (in_valid && cond_pass_c) begin
            case (mode_f)
                2'b00: begin
                    if (dp_ok_c) begin
                        dec_c.out_valid = 1'b1;
                        dec_c.exe_cmd   = dp_cmd_c;
                        dec_c.wb_en     = (opcode_f != 4'b1010) && (opcode_f != 4'b1000);
                        dec_c.s_update  = s_f || (opcode_f == 4'b1010) || (opcode_f == 4'b1000);
                    end
                end
                2'b01: begin
                    dec_c.out_valid = 1'b1;
                    dec_c.exe_cmd   = 4'b0010;
                    dec_c.mem_read  = s_f;
                    dec_c.mem_write = ~s_f;
                    dec_c.wb_en     = s_f;
                end
                2'b10: begin
                    dec_c.out_valid = 1'b1;
                    dec_c.branch    = 1'b1;
                end
                default: ;
            endcase
        end
        if (dec_c.out_valid) begin
            dec_c.imm           = instr[25];
            dec_c.carry_in      = flags_c[1];
            dec_c.rn            = instr[19:16];
            dec_c.rd            = instr[15:12];
            dec_c.shift_operand = instr[11:0];
            dec_c.branch_offset = instr[23:0];
        end
    end

    // flush beats stall; stall holds the register and ignores instr.
    always_comb begin
        idex_d = idex_q;
        if (flush) begin
            idex_d = '0;
        end else if (!stall) begin
            idex_d = dec_c;
        end
        status_d = ex_flags_we ? ex_flags : status_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q   <= '0;
            status_q <= 4'b0000;
        end else begin
            idex_q   <= idex_d;
            status_q <= status_d;
        end
    end

    assign exe_cmd       = idex_q.exe_cmd;
    assign carry_in      = idex_q.carry_in;
    assign out_valid     = idex_q.out_valid;
    assign wb_en         = idex_q.wb_en;
    assign mem_read      = idex_q.mem_read;
    assign mem_write     = idex_q.mem_write;
    assign s_update      = idex_q.s_update;
    assign imm           = idex_q.imm;
    assign branch        = idex_q.branch;
    assign rn            = idex_q.rn;
    assign rd            = idex_q.rd;
    assign shift_operand = idex_q.shift_operand;
    assign branch_offset = idex_q.branch_offset;
    assign status        = status_q;

endmodule

// File: tb/tb_id_ex_ctrl.sv
// Bench for id_ex_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_id_ex_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        in_valid, stall, flush, ex_flags_we;
    logic [3:0]  ex_flags;
    logic [3:0]  exe_cmd, rn, rd, status;
    logic        carry_in, out_valid, wb_en, mem_read, mem_write, s_update, imm, branch;
    logic [11:0] shift_operand;
    logic [23:0] branch_offset;

    int total = 0;
    int bad   = 0;
    int cmd_map [16];

    localparam logic [31:0] I_ADDS  = 32'hE292_1005;
    localparam logic [31:0] I_MOVEQ = 32'h03A0_0001;
    localparam logic [31:0] I_ADC   = 32'hE0A1_1002;
    localparam logic [31:0] I_LDR   = 32'hE594_3008;
    localparam logic [31:0] I_B     = 32'hEA00_0003;

    id_ex_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .in_valid(in_valid),
        .stall(stall), .flush(flush), .ex_flags(ex_flags), .ex_flags_we(ex_flags_we),
        .exe_cmd(exe_cmd), .carry_in(carry_in), .out_valid(out_valid), .wb_en(wb_en),
        .mem_read(mem_read), .mem_write(mem_write), .s_update(s_update), .imm(imm),
        .branch(branch), .rn(rn), .rd(rd), .shift_operand(shift_operand),
        .branch_offset(branch_offset), .status(status)
    );

    always #5 clk = ~clk;

    logic [55:0] obs;
    assign obs = {out_valid, wb_en, mem_read, mem_write, s_update, imm, branch, carry_in,
                  exe_cmd, rn, rd, shift_operand, branch_offset};

    // Expected registered payload for one decode, in the same field order as obs.
    function automatic logic [55:0] model(input logic [31:0] i, input logic v, input logic [3:0] f);
        logic n, z, c, ov, pass, wb, mr, mw, s, br;
        int   cmd;
        n = f[3]; z = f[2]; c = f[1]; ov = f[0];
        case (i[31:28])
            0: pass = z;            1: pass = !z;
            2: pass = c;            3: pass = !c;
            4: pass = n;            5: pass = !n;
            6: pass = ov;           7: pass = !ov;
            8: pass = c && !z;      9: pass = !c || z;
            10: pass = (n == ov);   11: pass = (n != ov);
            12: pass = !z && (n == ov);
            13: pass = z || (n != ov);
            14: pass = 1'b1;
            default: pass = 1'b0;
        endcase
        if (!v || !pass) return '0;
        wb = 0; mr = 0; mw = 0; s = 0; br = 0; cmd = 0;
        case (i[27:26])
            2'b00: begin
                cmd = cmd_map[i[24:21]];
                if (cmd < 0) return '0;
                wb = !(i[24:21] == 4'hA || i[24:21] == 4'h8);
                s  = i[20] || !wb;
            end
            2'b01: begin cmd = 2; mr = i[20]; mw = !i[20]; wb = i[20]; end
            2'b10: br = 1;
            default: return '0;
        endcase
        return {1'b1, wb, mr, mw, s, i[25], br, c, 4'(cmd), i[19:16], i[15:12], i[11:0], i[23:0]};
    endfunction

    task automatic idle();
        in_valid = 0; stall = 0; flush = 0; ex_flags_we = 0; ex_flags = 4'h0; instr = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 0; idle();
        repeat (2) @(negedge clk);
        total++;
        if ({obs, status} !== 60'h0) begin bad++; $display("FAIL reset_initial: got %h/%h want 0", obs, status); end
        rst_n = 1; instr = I_ADDS; in_valid = 1; ex_flags = 4'hF; ex_flags_we = 1;
        @(negedge clk);
        total++;
        if ({status, out_valid} !== 5'b11111) begin bad++; $display("FAIL reset_precond: got %b want 11111", {status, out_valid}); end
        idle();
        #2 rst_n = 0;
        #1;
        total++;
        if ({obs, status} !== 60'h0) begin bad++; $display("FAIL reset_async: got %h/%h want 0", obs, status); end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_adds();
        idle(); instr = I_ADDS; in_valid = 1;
        @(negedge clk);
        total++;
        if ({out_valid, wb_en, mem_read, mem_write, s_update, imm, branch, exe_cmd, rn, rd, shift_operand}
            !== {7'b1100110, 4'h2, 4'h2, 4'h1, 12'h005}) begin
            bad++; $display("FAIL adds: got %h", {out_valid, wb_en, mem_read, mem_write, s_update, imm, branch, exe_cmd, rn, rd, shift_operand});
        end
        idle(); @(negedge clk);
    endtask

    task automatic test_moveq_bypass();
        idle(); instr = I_MOVEQ; in_valid = 1; ex_flags = 4'b0100; ex_flags_we = 1;
        @(negedge clk);
        total++;
        if ({out_valid, wb_en, exe_cmd} !== 6'b11_0001) begin bad++; $display("FAIL moveq_bypass: got %b want 110001", {out_valid, wb_en, exe_cmd}); end
        idle(); ex_flags = 4'b0000; ex_flags_we = 1;
        @(negedge clk);
        idle(); instr = I_MOVEQ; in_valid = 1;
        @(negedge clk);
        total++;
        if ({out_valid, wb_en, exe_cmd} !== 6'b00_0000) begin bad++; $display("FAIL moveq_no_bypass: got %b want 000000", {out_valid, wb_en, exe_cmd}); end
        idle(); @(negedge clk);
    endtask

    task automatic test_adc();
        idle(); ex_flags = 4'b0010; ex_flags_we = 1;
        @(negedge clk);
        idle(); instr = I_ADC; in_valid = 1;
        @(negedge clk);
        total++;
        if ({exe_cmd, carry_in, s_update, wb_en, out_valid} !== 8'b0011_1011) begin
            bad++; $display("FAIL adc: got %b want 00111011", {exe_cmd, carry_in, s_update, wb_en, out_valid});
        end
        idle(); @(negedge clk);
    endtask

    task automatic test_ldr_branch();
        idle(); instr = I_LDR; in_valid = 1;
        @(negedge clk);
        total++;
        if ({mem_read, mem_write, wb_en, s_update, out_valid, exe_cmd, rn, rd} !== {5'b10101, 4'h2, 4'h4, 4'h3}) begin
            bad++; $display("FAIL ldr: got %h", {mem_read, mem_write, wb_en, s_update, out_valid, exe_cmd, rn, rd});
        end
        instr = I_B;
        @(negedge clk);
        total++;
        if ({branch, wb_en, mem_read, out_valid, exe_cmd, branch_offset} !== {4'b1001, 4'h0, 24'h000003}) begin
            bad++; $display("FAIL branch: got %h", {branch, wb_en, mem_read, out_valid, exe_cmd, branch_offset});
        end
        idle(); @(negedge clk);
    endtask

    task automatic test_stall_flush();
        logic [55:0] held;
        idle(); instr = I_ADDS; in_valid = 1;
        @(negedge clk);
        held = model(I_ADDS, 1'b1, status);
        stall = 1; instr = I_LDR;
        for (int k = 0; k < 3; k++) begin
            ex_flags_we = (k == 1); ex_flags = 4'b1010;
            @(negedge clk);
            total++;
            if (obs !== held) begin bad++; $display("FAIL stall_hold%0d: got %h want %h", k, obs, held); end
            if (k == 1) begin
                total++;
                if (status !== 4'b1010) begin bad++; $display("FAIL stall_status: got %b want 1010", status); end
            end
        end
        ex_flags_we = 0; flush = 1;
        @(negedge clk);
        total++;
        if (obs !== 56'h0) begin bad++; $display("FAIL stall_flush: got %h want 0", obs); end
        flush = 0; stall = 0; instr = I_ADDS;
        @(negedge clk);
        stall = 1; instr = I_LDR;
        #2 rst_n = 0;
        #1;
        total++;
        if ({obs, status} !== 60'h0) begin bad++; $display("FAIL reset_in_stall: got %h/%h want 0", obs, status); end
        @(negedge clk); rst_n = 1; idle(); @(negedge clk);
    endtask

    task automatic test_random();
        logic [55:0] exp_q;
        logic [3:0]  exp_status;
        logic [3:0]  byp;
        int          errs = 0;
        idle(); flush = 1; ex_flags_we = 1; ex_flags = 4'h0;
        @(negedge clk);
        exp_q = '0; exp_status = 4'h0;
        for (int n = 0; n < 2000; n++) begin
            instr       = $urandom;
            if ($urandom_range(1, 0) == 1) instr[31:28] = 4'hE;
            in_valid    = ($urandom_range(7, 0) != 0);
            stall       = ($urandom_range(5, 0) == 0);
            flush       = ($urandom_range(9, 0) == 0);
            ex_flags_we = ($urandom_range(2, 0) == 0);
            ex_flags    = 4'($urandom);
            byp = ex_flags_we ? ex_flags : exp_status;
            if (flush) exp_q = '0;
            else if (!stall) exp_q = model(instr, in_valid, byp);
            exp_status = byp;
            @(negedge clk);
            total++;
            if ({obs, status} !== {exp_q, exp_status}) begin
                bad++;
                if (errs < 10) $display("FAIL random%0d: instr %h got %h/%h want %h/%h", n, instr, obs, status, exp_q, exp_status);
                errs++;
            end
        end
        idle();
    endtask

    initial begin
        cmd_map = '{default: -1};
        cmd_map[4'b1101] = 1; cmd_map[4'b1111] = 9; cmd_map[4'b0100] = 2;
        cmd_map[4'b0101] = 3; cmd_map[4'b0010] = 4; cmd_map[4'b0110] = 5;
        cmd_map[4'b0000] = 6; cmd_map[4'b1100] = 7; cmd_map[4'b0001] = 8;
        cmd_map[4'b1010] = 4; cmd_map[4'b1000] = 6;
        test_reset();
        test_adds();
        test_moveq_bypass();
        test_adc();
        test_ldr_branch();
        test_stall_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
